// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// Defining UART_ARB_GAP_EN adds a GAP_CYC-cycle idle gap after every frame.
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 65535,
  parameter int GAP_CYC     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        uart_tx_start,
  output logic [DATA_W-1:0]           uart_tx_data,
  input  logic                        uart_tx_done,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  cur_src,
  output logic                        timeout_err
);

  localparam int          SRC_W  = $clog2(NUM_REQ);
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
  localparam bit          TO_EN  = (TIMEOUT_CYC != 0);

`ifdef UART_ARB_GAP_EN
  localparam logic [15:0] GAP_LOAD = 16'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;
`endif

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  start_q, start_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [SRC_W-1:0]      src_q, src_d;
  logic                  to_q, to_d;
  logic                  busy_q, busy_d;
  logic [15:0]           wd_q, wd_d;
  logic [SRC_W-1:0]      ptr_q, ptr_d;
  logic                  frame_end;

  logic [DATA_W-1:0]     req_bytes [NUM_REQ];
  logic                  found;
  logic [SRC_W-1:0]      pick;
  logic [SRC_W-1:0]      scan_w;
  int                    scan_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // First requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = 0;
    scan_w   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      scan_w = SRC_W'(scan_idx);
      if (!found && req[scan_w]) begin
        found = 1'b1;
        pick  = scan_w;
      end
    end
  end

`ifdef UART_ARB_GAP_EN
  logic [15:0] gap_q, gap_d;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    start_d   = 1'b0;
    data_d    = data_q;
    src_d     = src_q;
    to_d      = 1'b0;
    wd_d      = wd_q;
    ptr_d     = ptr_q;
    frame_end = 1'b0;
`ifdef UART_ARB_GAP_EN
    gap_d     = gap_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d[pick] = 1'b1;
          data_d      = req_bytes[pick];
          src_d       = pick;
          ptr_d       = (pick == SRC_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done has priority over a watchdog expiry in the same cycle
        if (uart_tx_done) begin
          frame_end = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
          if (TO_EN && (wd_d == TO_LIM)) begin
            to_d      = 1'b1;
            frame_end = 1'b1;
          end
        end
      end
`ifdef UART_ARB_GAP_EN
      S_GAP: begin
        if (gap_q == 16'd0) state_d = S_IDLE;
        else                gap_d   = gap_q - 16'd1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (frame_end) begin
`ifdef UART_ARB_GAP_EN
      state_d = S_GAP;
      gap_d   = GAP_LOAD;
`else
      state_d = S_IDLE;
`endif
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
      wd_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      data_q  <= data_d;
      src_q   <= src_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      wd_q    <= wd_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef UART_ARB_GAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gap_q <= '0;
    else      gap_q <= gap_d;
  end
`endif

  assign gnt           = gnt_q;
  assign uart_tx_start = start_q;
  assign uart_tx_data  = data_q;
  assign busy          = busy_q;
  assign cur_src       = src_q;
  assign timeout_err   = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a cycle-count reference model.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int NR      = 4;
  localparam int DW      = 8;
  localparam int TO_CYC  = 20;
  localparam int GAP_CYC = 5;
`ifdef UART_ARB_GAP_EN
  localparam int GAP_M = GAP_CYC;
`else
  localparam int GAP_M = 0;
`endif

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_v;
  logic [DW-1:0]   bytes [NR];
  logic [NR*DW-1:0] req_data_flat;
  logic [NR-1:0]   gnt;
  logic            uart_tx_start;
  logic [DW-1:0]   uart_tx_data;
  logic            done_v;
  logic            busy;
  logic [1:0]      cur_src;
  logic            timeout_err;

  assign req_data_flat = {bytes[3], bytes[2], bytes[1], bytes[0]};

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req_v), .req_data(req_data_flat), .gnt(gnt),
    .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
    .uart_tx_done(done_v), .busy(busy), .cur_src(cur_src), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: frames tracked by the edge number of their grant.
  int          n, m_g, m_free, m_ptr, m_src;
  bit          m_act;
  logic [7:0]  m_data;
  logic [3:0]  e_gnt;
  bit          e_start, e_to, e_busy;
  int          glog[$];
  int          to_seen;
  int          last_done_n;
  logic [3:0]  keep;
  bit          auto_done;
  int          auto_dly, done_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; m_g = 0; m_free = 0; m_ptr = 0; m_src = 0; m_act = 0; m_data = '0;
    done_cnt = 0;
  endtask

  task automatic model_edge();
    n++;
    e_gnt = '0; e_start = 0; e_to = 0;
    if (m_act) begin
      if (n >= m_g + 2 && done_v) begin
        m_act = 0; m_free = n + 1 + GAP_M;
      end else if (TO_CYC != 0 && n == m_g + 1 + TO_CYC) begin
        m_act = 0; m_free = n + 1 + GAP_M; e_to = 1;
      end else if (n == m_g + 1) begin
        e_start = 1;
      end
    end else if (n >= m_free && req_v != 0) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (req_v[idx]) begin
          e_gnt[idx] = 1'b1;
          m_src  = idx;
          m_data = bytes[idx];
          m_ptr  = (idx + 1) % NR;
          m_g    = n;
          m_act  = 1;
          glog.push_back(idx);
          break;
        end
      end
    end
    e_busy = m_act || (n < m_free - 1);
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_edge();
    check_eq("gnt", gnt, e_gnt);
    check_eq("tx_start", uart_tx_start, e_start);
    check_eq("tx_data", uart_tx_data, m_data);
    check_eq("cur_src", cur_src, m_src);
    check_eq("busy", busy, e_busy);
    check_eq("timeout_err", timeout_err, e_to);
    if (timeout_err) to_seen++;
    for (int i = 0; i < NR; i++)
      if (gnt[i]) begin
        if (keep[i]) bytes[i] = 8'($urandom);
        else         req_v[i] = 1'b0;
      end
    done_v = 1'b0;
    if (auto_done) begin
      if (uart_tx_start) done_cnt = auto_dly;
      else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin done_v = 1'b1; last_done_n = n; end
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < limit) begin step(); c++; end
    check_eq("idle_reached", busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, t, gsz, tb0;
    rst = 1'b0; req_v = '0; done_v = 1'b0; keep = '0; auto_done = 0; auto_dly = 2;
    to_seen = 0; last_done_n = -1;
    for (int i = 0; i < NR; i++) bytes[i] = '0;
    model_reset();
    #1;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_start", uart_tx_start, 0);
    check_eq("rst_data", uart_tx_data, 0);
    check_eq("rst_src", cur_src, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_timeout", timeout_err, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    model_reset();

    // round-robin with all four requesters held
    bytes[0] = 8'hA0; bytes[1] = 8'hA1; bytes[2] = 8'hA2; bytes[3] = 8'hA3;
    keep = 4'hF; req_v = 4'hF; auto_done = 1; auto_dly = 2; glog.delete();
    for (int c = 0; c < 200 && glog.size() < 5; c++) begin
      step();
      if (uart_tx_start && last_done_n >= 0) check_eq("rr_start_spacing", n - last_done_n, 3 + GAP_M);
    end
    check_eq("rr_grant_count", glog.size(), 5);
    for (int k = 0; k < glog.size(); k++) check_eq("rr_order", glog[k], k % NR);
    keep = '0; req_v = '0;
    wait_idle(100);

    // single request, done 10 cycles after start
    auto_dly = 10; bytes[0] = 8'h55; req_v = 4'b0001;
    step();
    check_eq("single_gnt", gnt, 4'b0001);
    step();
    check_eq("single_start", uart_tx_start, 1);
    check_eq("single_data", uart_tx_data, 8'h55);
    for (int c = 0; c < 40; c++) begin
      step();
      if (done_v) begin
        step();
        check_eq("single_busy_fall", busy, 0);
        break;
      end
    end
    wait_idle(50);

    // fairness: req0 held, req2 raised mid-frame
    glog.delete(); auto_dly = 4; keep = 4'b0001;
    bytes[0] = 8'hB0; req_v = 4'b0001;
    step(); step();
    bytes[2] = 8'hC2; req_v[2] = 1'b1;
    for (int c = 0; c < 100 && glog.size() < 3; c++) step();
    check_eq("fair_count", glog.size(), 3);
    for (int k = 0; k < glog.size(); k++) check_eq("fair_order", glog[k], (k == 1) ? 2 : 0);
    keep = '0; req_v = '0;
    wait_idle(100);

    // watchdog expiry, pending request served next
    auto_done = 0; bytes[1] = 8'h3C; req_v = 4'b0010;
    s = -1;
    for (int c = 0; c < 20 && s < 0; c++) begin step(); if (uart_tx_start) s = n; end
    check_eq("wd_start_seen", s >= 0, 1);
    bytes[3] = 8'hC3; req_v[3] = 1'b1;
    t = -1;
    for (int c = 0; c < 40 && t < 0; c++) begin step(); if (timeout_err) t = n; end
    check_eq("wd_latency", t - s, TO_CYC);
    gsz = glog.size();
    for (int c = 0; c < 10 && glog.size() == gsz; c++) step();
    check_eq("wd_next_grant", glog[$], 3);
    auto_done = 1; auto_dly = 4;
    wait_idle(60);

    // done coinciding with expiry wins; one cycle later it does not
    tb0 = to_seen; auto_dly = 19; bytes[0] = 8'h99; req_v = 4'b0001;
    step();
    wait_idle(80);
    check_eq("tie_no_timeout", to_seen - tb0, 0);
    tb0 = to_seen; auto_dly = 20; bytes[0] = 8'h9A; req_v = 4'b0001;
    step();
    wait_idle(80);
    check_eq("late_done_timeout", to_seen - tb0, 1);

    // randomized traffic
    auto_done = 0;
    for (int c = 0; c < 3000; c++) begin
      keep = 4'($urandom);
      step();
      done_v = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!req_v[i]) begin
          if ($urandom_range(0, 3) == 0) begin req_v[i] = 1'b1; bytes[i] = 8'($urandom); end
        end else if (!gnt[i] && $urandom_range(0, 31) == 0) begin
          req_v[i] = 1'b0;
        end
      end
    end
    req_v = '0; done_v = 1'b0; keep = '0; auto_done = 1; auto_dly = 3;
    wait_idle(100);

    // asynchronous reset during WAIT
    auto_done = 0; bytes[0] = 8'h5A; req_v = 4'b0001;
    step(); step(); step();
    check_eq("rst_mid_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_gnt", gnt, 0);
    check_eq("arst_start", uart_tx_start, 0);
    check_eq("arst_data", uart_tx_data, 0);
    check_eq("arst_src", cur_src, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_timeout", timeout_err, 0);
    req_v = 4'b0100; bytes[2] = 8'h77;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    model_reset();
    step();
    check_eq("post_rst_gnt", gnt, 4'b0100);
    check_eq("post_rst_src", cur_src, 2);
    auto_done = 1; auto_dly = 2;
    wait_idle(60);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (uart_top tx_start/tx_data/tx_done interface) between NUM_REQ byte producers.
- Picks one requester per frame by round-robin and latches its byte.
- Issues a one-cycle start pulse to the transmitter, then holds until the frame completes or a watchdog expires.
- Sits between the producer blocks and uart_top.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: frame data width.
- TIMEOUT_CYC, 65535: maximum cycles in WAIT before abort; 0 disables the watchdog. Counter is 16 bits.
- GAP_CYC, 16: idle cycles inserted after each frame. Used only when UART_ARB_GAP_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester send request, level.
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i uses bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot, one-cycle pulse; byte of requester i has been accepted.
- uart_tx_start  out  1  one-cycle start pulse to the transmitter.
- uart_tx_data  out  DATA_W  latched byte to the transmitter.
- uart_tx_done  in  1  one-cycle pulse from the transmitter at end of frame.
- busy  out  1  high whenever the state is not IDLE.
- cur_src  out  clog2(NUM_REQ)  index of the last granted requester.
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - gnt, uart_tx_start, uart_tx_data, cur_src, timeout_err, watchdog counter, gap counter all 0.
  - Round-robin pointer set to 0, so requester 0 has highest priority first.
  - Reset mid-frame abandons the frame silently. No gnt or timeout_err is generated.
- All outputs are registered.
- States: IDLE, START, WAIT, GAP (GAP exists only with the macro).
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise grant the first set bit scanning from the pointer upward, wrapping modulo NUM_REQ.
  - At that edge: gnt[i]=1, uart_tx_data=req_data[i], cur_src=i, pointer=(i+1) mod NUM_REQ, state goes to START.
- START:
  - gnt returns to 0.
  - uart_tx_start=1 for exactly this one cycle.
  - Watchdog cleared; state goes to WAIT.
- WAIT:
  - uart_tx_start=0; uart_tx_data held stable.
  - When uart_tx_done=1, go to IDLE (or GAP with the macro).
  - Watchdog increments every cycle while uart_tx_done=0.
  - If TIMEOUT_CYC!=0 and the count reaches TIMEOUT_CYC: pulse timeout_err for one cycle, go to IDLE (or GAP with the macro).
  - If uart_tx_done and timeout fall in the same cycle, done wins and there is no timeout_err.
- uart_tx_done is ignored outside WAIT.
- Latency: req seen at clock edge t gives gnt high in cycle t+1 and uart_tx_start high in cycle t+2. Back-to-back frames have minimum spacing of 1 IDLE cycle after done.
- Requester handshake:
  - The requester holds req and req_data stable until it sees gnt[i].
  - It drops req in the cycle after gnt, or keeps it high to queue another byte.
  - Dropping req before gnt withdraws the request with no side effects.
- Fairness: a requester that holds req continuously cannot be granted twice while another requester is waiting.
- cur_src holds its value until the next grant.
- busy=0 only in IDLE.

Optional Feature:
- Macro: UART_ARB_GAP_EN.
- Defined:
  - After done or timeout, enter GAP and count GAP_CYC cycles with busy=1, then return to IDLE.
  - Requests are not granted during GAP.
  - Reset clears the gap counter.
- Undefined:
  - GAP state and counter are absent.
  - WAIT goes directly to IDLE; GAP_CYC is unused.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'h55, tx_done pulsed 10 cycles after start.
  - gnt=0001 one cycle after req.
  - uart_tx_start one cycle later with uart_tx_data=8'h55.
  - busy falls one cycle after tx_done.
- Round-robin: req=4'b1111 held, bytes 8'hA0..8'hA3, each frame acknowledged.
  - Grant order is 0,1,2,3,0.
  - cur_src follows; uart_tx_data matches each byte.
- Fairness: req0 held permanently, req2 raised mid-frame 0.
  - Next grant is 2, then 0.
  - req0 is never granted twice in a row while req2 is pending.
- Watchdog: TIMEOUT_CYC=20, tx_done never pulsed.
  - timeout_err pulses exactly 20 cycles after entering WAIT.
  - State returns to IDLE; the next pending req is granted.
- Reset mid-frame: rst=0 during WAIT.
  - All outputs 0 immediately (asynchronous).
  - After release, req=4'b0100 is granted first because pointer=0 and only req2 is set.
- UART_ARB_GAP_EN with GAP_CYC=5, two queued requests:
  - Second uart_tx_start occurs 5+3 cycles after the first tx_done.
  - busy stays high through the gap.
